// File: rtl/gbc_gamepak_pkg.sv
// Shared types and constants for the GamePak MBC5 cartridge mapper.
package gbc_gamepak_pkg;

  typedef enum logic [2:0] {
    RegionRom0,
    RegionRomX,
    RegionVramNone,
    RegionXram,
    RegionOther
  } region_e;

  // Register pages are decoded from the top address bits only.
  localparam logic [2:0] RegRamEnPage   = 3'b000;
  localparam logic [3:0] RegRomLoPage   = 4'h2;
  localparam logic [3:0] RegRomHiPage   = 4'h3;
  localparam logic [2:0] RegRamBankPage = 3'b010;

  localparam logic [7:0] RamEnKey   = 8'h0A;
  localparam logic [7:0] PakOpenBus = 8'hFF;

  function automatic region_e region_of(input logic [15:0] addr);
    region_e r;
    unique casez (addr[15:13])
      3'b00?:  r = RegionRom0;
      3'b01?:  r = RegionRomX;
      3'b100:  r = RegionVramNone;
      3'b101:  r = RegionXram;
      default: r = RegionOther;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gbc_mbc5_regs.sv
// MBC5 bank/enable registers and the combinational console-to-memory address mapper.
module gbc_mbc5_regs
  import gbc_gamepak_pkg::*;
#(
  parameter int unsigned           ROM_BANK_W    = 9,
  parameter int unsigned           RAM_BANK_W    = 4,
  parameter int unsigned           MEM_AW        = 24,
  parameter logic [ROM_BANK_W-1:0] ROM_BANK_MASK = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pak_reset,
  input  logic              reg_we,
  input  logic [15:0]       reg_addr,
  input  logic [7:0]        reg_data,
  input  logic [15:0]       map_addr,
  input  logic              map_cs,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              hit,
  output logic              ram
);

  logic [ROM_BANK_W-1:0] rom_bank_q;
  logic [RAM_BANK_W-1:0] ram_bank_q;
  logic                  ram_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_bank_q <= ROM_BANK_W'(1);
      ram_bank_q <= '0;
      ram_en_q   <= 1'b0;
    end else if (pak_reset) begin
      rom_bank_q <= ROM_BANK_W'(1);
      ram_bank_q <= '0;
      ram_en_q   <= 1'b0;
    end else if (reg_we) begin
      if (reg_addr[15:13] == RegRamEnPage) begin
        ram_en_q <= (reg_data == RamEnKey);
      end else if (reg_addr[15:12] == RegRomLoPage) begin
        rom_bank_q[7:0] <= reg_data;
      end else if (reg_addr[15:12] == RegRomHiPage) begin
        rom_bank_q[ROM_BANK_W-1:8] <= reg_data[ROM_BANK_W-9:0];
      end else if (reg_addr[15:13] == RegRamBankPage) begin
        ram_bank_q <= reg_data[RAM_BANK_W-1:0];
      end
    end
  end

  // Bank 0 is deliberately reachable through the switchable window.
  always_comb begin
    mem_addr = '0;
    hit      = 1'b0;
    ram      = 1'b0;
    unique case (region_of(map_addr))
      RegionRom0: begin
        hit      = 1'b1;
        mem_addr = MEM_AW'(map_addr[13:0]);
      end
      RegionRomX: begin
        hit      = 1'b1;
        mem_addr = MEM_AW'({rom_bank_q & ROM_BANK_MASK, map_addr[13:0]});
      end
      RegionXram: begin
        if (map_cs && ram_en_q) begin
          hit      = 1'b1;
          ram      = 1'b1;
          mem_addr = {1'b1, (MEM_AW-1)'({ram_bank_q, map_addr[12:0]})};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gbc_gamepak_mbc5.sv
// MBC5 GamePak responder: bus edge detection, one-deep pending slot and memory request FSM.
module gbc_gamepak_mbc5
  import gbc_gamepak_pkg::*;
#(
  parameter int unsigned           ROM_BANK_W    = 9,
  parameter int unsigned           RAM_BANK_W    = 4,
  parameter int unsigned           MEM_AW        = 24,
  parameter logic [ROM_BANK_W-1:0] ROM_BANK_MASK = 9'h1FF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PakWrite,
  input  logic              PakRead,
  input  logic              PakCS,
  input  logic [15:0]       PakAddress,
  input  logic [7:0]        PakDIn,
  output logic [7:0]        PakDOut,
  input  logic              PakReset,
  output logic              PakAudio,
  output logic              MemReq,
  output logic              MemWe,
  output logic [MEM_AW-1:0] MemAddr,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData,
  input  logic              MemAck,
  output logic              Busy,
  output logic              Overrun
);

  typedef enum logic {StIdle, StReq} state_e;

  state_e            state_q;
  logic              rd_q, wr_q;
  logic [15:0]       addr_q;
  logic              rd_ev, wr_ev, mem_ev, open_rd;
  logic [MEM_AW-1:0] map_addr;
  logic              map_hit, map_ram;
  logic              pend_q, pend_we_q, discard_q;
  logic [MEM_AW-1:0] pend_addr_q;
  logic [7:0]        pend_wdata_q;

  assign rd_ev    = PakRead && (!rd_q || (PakAddress != addr_q));
  assign wr_ev    = PakWrite && !wr_q;
  // A write event wins over a simultaneous read event.
  assign mem_ev   = !PakReset && (wr_ev ? map_ram : (rd_ev && map_hit));
  assign open_rd  = !PakReset && !wr_ev && rd_ev && !map_hit;
  assign Busy     = (state_q != StIdle);
  assign PakAudio = 1'b0;

  gbc_mbc5_regs #(
    .ROM_BANK_W    (ROM_BANK_W),
    .RAM_BANK_W    (RAM_BANK_W),
    .MEM_AW        (MEM_AW),
    .ROM_BANK_MASK (ROM_BANK_MASK)
  ) u_regs (
    .clk       (Clk),
    .rst       (Reset),
    .pak_reset (PakReset),
    .reg_we    (wr_ev && !PakReset),
    .reg_addr  (PakAddress),
    .reg_data  (PakDIn),
    .map_addr  (PakAddress),
    .map_cs    (PakCS),
    .mem_addr  (map_addr),
    .hit       (map_hit),
    .ram       (map_ram)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      discard_q    <= 1'b0;
      PakDOut      <= PakOpenBus;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemAddr      <= '0;
      MemWData     <= '0;
      Overrun      <= 1'b0;
    end else begin
      rd_q    <= PakRead;
      wr_q    <= PakWrite;
      addr_q  <= PakAddress;
      Overrun <= 1'b0;
      if (open_rd) PakDOut <= PakOpenBus;
      unique case (state_q)
        StIdle: begin
          if (mem_ev) begin
            state_q   <= StReq;
            MemReq    <= 1'b1;
            MemWe     <= wr_ev;
            MemAddr   <= map_addr;
            MemWData  <= PakDIn;
            discard_q <= 1'b0;
          end
        end
        StReq: begin
          if (PakReset) begin
            // In-flight access is allowed to finish but its data is thrown away.
            pend_q <= 1'b0;
            if (MemAck) begin
              state_q <= StIdle;
              MemReq  <= 1'b0;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (MemAck) begin
            if (!MemWe && !discard_q && !open_rd) PakDOut <= MemRData;
            discard_q <= 1'b0;
            if (pend_q) begin
              MemWe        <= pend_we_q;
              MemAddr      <= pend_addr_q;
              MemWData     <= pend_wdata_q;
              pend_q       <= mem_ev;
              pend_we_q    <= wr_ev;
              pend_addr_q  <= map_addr;
              pend_wdata_q <= PakDIn;
            end else if (mem_ev) begin
              MemWe    <= wr_ev;
              MemAddr  <= map_addr;
              MemWData <= PakDIn;
            end else begin
              state_q <= StIdle;
              MemReq  <= 1'b0;
            end
          end else if (mem_ev) begin
            if (pend_q) begin
              Overrun <= 1'b1;
            end else begin
              pend_q       <= 1'b1;
              pend_we_q    <= wr_ev;
              pend_addr_q  <= map_addr;
              pend_wdata_q <= PakDIn;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gbc_gamepak_mbc5.sv
// Randomised bench for the MBC5 mapper against a queue-based model of accepted accesses.
module tb_gbc_gamepak_mbc5;

  logic        Clk, Reset, PakWrite, PakRead, PakCS, PakReset, MemAck;
  logic [15:0] PakAddress;
  logic [7:0]  PakDIn, MemRData;
  logic [7:0]  PakDOut, m_dout, MemWData, m_wdata;
  logic        PakAudio, m_audio, MemReq, m_req, MemWe, m_we, Busy, m_busy, Overrun, m_ovr;
  logic [23:0] MemAddr, m_addr;

  gbc_gamepak_mbc5 dut (
    .Clk(Clk), .Reset(Reset), .PakWrite(PakWrite), .PakRead(PakRead), .PakCS(PakCS),
    .PakAddress(PakAddress), .PakDIn(PakDIn), .PakDOut(PakDOut), .PakReset(PakReset),
    .PakAudio(PakAudio), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck), .Busy(Busy), .Overrun(Overrun)
  );

  // Same stimulus, smaller cart: only the ROMX mapping differs.
  gbc_gamepak_mbc5 #(.ROM_BANK_MASK(9'h0FF)) dut_m (
    .Clk(Clk), .Reset(Reset), .PakWrite(PakWrite), .PakRead(PakRead), .PakCS(PakCS),
    .PakAddress(PakAddress), .PakDIn(PakDIn), .PakDOut(m_dout), .PakReset(PakReset),
    .PakAudio(m_audio), .MemReq(m_req), .MemWe(m_we), .MemAddr(m_addr),
    .MemWData(m_wdata), .MemRData(MemRData), .MemAck(MemAck), .Busy(m_busy), .Overrun(m_ovr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [23:0] addr_m;
    logic [7:0]  wdata;
    logic        discard;
  } acc_t;

  acc_t        q[$];  // q[0] is in flight, q[1] is the pending slot
  int          rom_bank, ram_bank;
  logic        ram_en, prev_rd, prev_wr;
  logic [15:0] prev_addr;
  logic [7:0]  exp_dout;
  logic        exp_ovr;

  function automatic logic [23:0] rom_addr(input int bank, input int mask, input int a);
    return 24'(((bank & mask) * 16384) + (a % 16384));
  endfunction

  task automatic push_acc(input acc_t a);
    if (q.size() < 2) q.push_back(a);
    else exp_ovr = 1'b1;
  endtask

  always @(posedge Clk or posedge Reset) begin : model
    acc_t        a;
    logic        rd_ev, wr_ev, acked, in_ram;
    int          ai;
    logic [23:0] ram_a;
    if (Reset) begin
      q.delete();
      rom_bank = 1; ram_bank = 0; ram_en = 1'b0;
      prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0;
      exp_dout = 8'hFF; exp_ovr = 1'b0;
    end else begin
      exp_ovr = 1'b0;
      rd_ev   = PakRead && (!prev_rd || PakAddress != prev_addr);
      wr_ev   = PakWrite && !prev_wr;
      acked   = MemAck && q.size() > 0;
      ai      = int'(PakAddress);
      if (PakReset) begin
        if (acked || q.size() == 0) q.delete();
        else begin
          a = q[0]; a.discard = 1'b1; q.delete(); q.push_back(a);
        end
        rom_bank = 1; ram_bank = 0; ram_en = 1'b0;
      end else begin
        if (acked) begin
          a = q.pop_front();
          if (!a.we && !a.discard) exp_dout = MemRData;
        end
        in_ram = ai >= 'hA000 && ai < 'hC000 && PakCS && ram_en;
        ram_a  = 24'h800000 + 24'(ram_bank * 8192 + ai % 8192);
        if (wr_ev) begin
          if (in_ram) push_acc('{1'b1, ram_a, ram_a, PakDIn, 1'b0});
          else if (ai < 'h2000) ram_en = (PakDIn == 8'h0A);
          else if (ai < 'h3000) rom_bank = (rom_bank & 'h100) | int'(PakDIn);
          else if (ai < 'h4000) rom_bank = (rom_bank & 'hFF) | (PakDIn[0] ? 'h100 : 0);
          else if (ai < 'h6000) ram_bank = int'(PakDIn) % 16;
        end else if (rd_ev) begin
          if (ai < 'h4000) push_acc('{1'b0, 24'(ai), 24'(ai), 8'h00, 1'b0});
          else if (ai < 'h8000)
            push_acc('{1'b0, rom_addr(rom_bank, 'h1FF, ai), rom_addr(rom_bank, 'h0FF, ai),
                       8'h00, 1'b0});
          else if (in_ram) push_acc('{1'b0, ram_a, ram_a, 8'h00, 1'b0});
          else exp_dout = 8'hFF;
        end
      end
      prev_rd = PakRead; prev_wr = PakWrite; prev_addr = PakAddress;
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic chk_en = 1'b0;

  always @(negedge Clk) begin
    if (chk_en && !Reset) begin
      check_eq("req", 32'(MemReq), 32'(q.size() > 0));
      check_eq("busy", 32'(Busy), 32'(q.size() > 0));
      check_eq("overrun", 32'(Overrun), 32'(exp_ovr));
      check_eq("dout", 32'(PakDOut), 32'(exp_dout));
      check_eq("audio", 32'(PakAudio), 32'(1'b0));
      check_eq("req_m", 32'(m_req), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check_eq("addr", 32'(MemAddr), 32'(q[0].addr));
        check_eq("addr_m", 32'(m_addr), 32'(q[0].addr_m));
        check_eq("we", 32'(MemWe), 32'(q[0].we));
        if (q[0].we) check_eq("wdata", 32'(MemWData), 32'(q[0].wdata));
      end
    end
  end

  // ---------------- memory responder ----------------
  logic hold = 1'b1;
  int   ack_wait = 0;

  always @(negedge Clk) begin
    if (!hold) begin
      if (MemAck) MemAck = 1'b0;
      else if (MemReq && !Reset) begin
        if (ack_wait == 0) begin
          MemAck   = 1'b1;
          MemRData = 8'($urandom);
          ack_wait = $urandom_range(0, 3);
        end else ack_wait--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_read(input logic [15:0] a);
    @(negedge Clk); PakAddress = a; PakRead = 1'b1;
    @(negedge Clk); PakRead = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic cs);
    @(negedge Clk); PakAddress = a; PakDIn = d; PakCS = cs; PakWrite = 1'b1;
    @(negedge Clk); PakWrite = 1'b0;
  endtask

  task automatic mem_ack(input logic [7:0] d);
    @(negedge Clk); MemAck = 1'b1; MemRData = d;
    @(negedge Clk); MemAck = 1'b0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(16'h0000, 16'h3FFF));
      1:       return 16'($urandom_range(16'h4000, 16'h7FFF));
      2, 3:    return 16'($urandom_range(16'hA000, 16'hBFFF));
      4:       return 16'($urandom_range(16'h8000, 16'h9FFF));
      default: return 16'($urandom_range(16'hC000, 16'hFFFF));
    endcase
  endfunction

  initial begin
    Reset = 1'b1; PakWrite = 1'b0; PakRead = 1'b0; PakCS = 1'b0; PakReset = 1'b0;
    MemAck = 1'b0; PakAddress = '0; PakDIn = '0; MemRData = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0; chk_en = 1'b1;
    @(negedge Clk);
    check_eq("rst_req", 32'(MemReq), 32'(1'b0));
    check_eq("rst_addr", 32'(MemAddr), 32'(24'h0));
    check_eq("rst_we", 32'(MemWe), 32'(1'b0));
    check_eq("rst_wdata", 32'(MemWData), 32'(8'h00));
    check_eq("rst_dout", 32'(PakDOut), 32'(8'hFF));

    // 1: basic ROMX read in bank 1
    bus_read(16'h4005);
    check_eq("t1_req", 32'(MemReq), 32'(1'b1));
    check_eq("t1_addr", 32'(MemAddr), 32'(24'h004005));
    mem_ack(8'h3C);
    check_eq("t1_dout", 32'(PakDOut), 32'(8'h3C));

    // 2: 9-bit bank and mask
    bus_write(16'h2000, 8'h25, 1'b0);
    bus_write(16'h3000, 8'h01, 1'b0);
    bus_read(16'h4123);
    check_eq("t2_addr", 32'(MemAddr), 32'(24'h494123));
    check_eq("t2_addr_m", 32'(m_addr), 32'(24'h094123));
    mem_ack(8'h5A);

    // 3: disabled RAM then enabled RAM write
    PakCS = 1'b1;
    bus_read(16'hA010);
    check_eq("t3_noreq", 32'(MemReq), 32'(1'b0));
    check_eq("t3_open", 32'(PakDOut), 32'(8'hFF));
    bus_write(16'h0000, 8'h0A, 1'b1);
    bus_write(16'h4000, 8'h03, 1'b1);
    bus_write(16'hA010, 8'h77, 1'b1);
    check_eq("t3_we", 32'(MemWe), 32'(1'b1));
    check_eq("t3_addr", 32'(MemAddr), 32'(24'h806010));
    check_eq("t3_wdata", 32'(MemWData), 32'(8'h77));
    mem_ack(8'h00);

    // 4: in-flight, pending, dropped
    bus_read(16'h0100);
    bus_read(16'h0200);
    bus_read(16'h0300);
    check_eq("t4_ovr", 32'(Overrun), 32'(1'b1));
    @(negedge Clk);
    check_eq("t4_ovr_pulse", 32'(Overrun), 32'(1'b0));
    mem_ack(8'h11);
    check_eq("t4_dout1", 32'(PakDOut), 32'(8'h11));
    check_eq("t4_b2b_req", 32'(MemReq), 32'(1'b1));
    check_eq("t4_b2b_addr", 32'(MemAddr), 32'(24'h000200));
    mem_ack(8'h22);
    check_eq("t4_dout2", 32'(PakDOut), 32'(8'h22));
    check_eq("t4_idle", 32'(MemReq), 32'(1'b0));

    // 5: cart reset during a read, then system reset during a request
    bus_read(16'h4000);
    @(negedge Clk); PakReset = 1'b1;
    @(negedge Clk); PakReset = 1'b0;
    mem_ack(8'h99);
    check_eq("t5_dout_kept", 32'(PakDOut), 32'(8'h22));
    bus_read(16'h4000);
    check_eq("t5_bank1", 32'(MemAddr), 32'(24'h004000));
    mem_ack(8'h01);
    bus_read(16'hA010);
    check_eq("t5_ramoff", 32'(MemReq), 32'(1'b0));
    bus_read(16'h1234);
    #3 Reset = 1'b1;
    #1 check_eq("t5_async_req", 32'(MemReq), 32'(1'b0));
    check_eq("t5_async_busy", 32'(Busy), 32'(1'b0));
    @(negedge Clk); Reset = 1'b0;
    mem_ack(8'h44);
    check_eq("t5_late_ack", 32'(PakDOut), 32'(8'hFF));

    // 6: bank write coincident with an ack
    bus_read(16'h0050);
    @(negedge Clk);
    MemAck = 1'b1; MemRData = 8'h6E;
    PakAddress = 16'h2000; PakDIn = 8'h07; PakWrite = 1'b1;
    @(negedge Clk);
    MemAck = 1'b0; PakWrite = 1'b0;
    check_eq("t6_dout", 32'(PakDOut), 32'(8'h6E));
    bus_read(16'h4000);
    check_eq("t6_bank7", 32'(MemAddr), 32'(24'h01C000));
    mem_ack(8'h02);

    // Random traffic with a randomly stalling memory
    hold = 1'b0;
    for (int i = 0; i < 500; i++) begin
      logic [15:0] a;
      a = pick_addr();
      PakCS = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: bus_read(a);
        3: begin
          @(negedge Clk); PakAddress = a; PakRead = 1'b1;
          @(negedge Clk); PakAddress = pick_addr();
          @(negedge Clk); PakRead = 1'b0;
        end
        4: bus_write(16'($urandom_range(0, 16'h1FFF)),
                     ($urandom_range(0, 2) != 0) ? 8'h0A : 8'($urandom), PakCS);
        5: bus_write(16'($urandom_range(16'h2000, 16'h2FFF)), 8'($urandom), PakCS);
        6: bus_write(16'($urandom_range(16'h3000, 16'h3FFF)), 8'($urandom), PakCS);
        7: bus_write(16'($urandom_range(16'h4000, 16'h7FFF)), 8'($urandom), PakCS);
        8: bus_write(16'($urandom_range(16'hA000, 16'hBFFF)), 8'($urandom), PakCS);
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            @(negedge Clk); PakReset = 1'b1;
            @(negedge Clk); PakReset = 1'b0;
          end else repeat ($urandom_range(1, 4)) @(negedge Clk);
        end
      endcase
    end

    for (int i = 0; i < 60 && (MemReq || q.size() > 0); i++) @(negedge Clk);
    check_eq("drain_idle", 32'(MemReq), 32'(1'b0));
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gbc_gamepak_mbc5.md
Name: gbc_gamepak_mbc5

Overview:
- Cartridge-side responder for the GamePak bus; the console core is the initiator.
- Emulates an MBC5 mapper: decodes console bus cycles, maintains the bank registers, and translates each access into a request on the backing ROM/RAM memory port.
- Returns read data on the pak data-out line.
- Sits between the GamePak interface and the SDRAM/BRAM arbiter.

Parameters:
- ROM_BANK_W, 9: ROM bank register width (512 x 16 KiB).
- RAM_BANK_W, 4: RAM bank register width (16 x 8 KiB).
- MEM_AW, 24: backing-memory byte-address width. Bit MEM_AW-1 selects the RAM region.
- ROM_BANK_MASK, 9'h1FF: AND-mask applied to the ROM bank for cart size.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PakWrite  in  1  console write strobe.
- PakRead  in  1  console read strobe.
- PakCS  in  1  external-RAM chip select, active-high.
- PakAddress  in  16  console address.
- PakDIn  in  8  console write data.
- PakDOut  out  8  read data to the console.
- PakReset  in  1  console cart reset; synchronous effect.
- PakAudio  out  1  cart audio; driven constant 0.
- MemReq  out  1  memory request, held until MemAck.
- MemWe  out  1  1 = write, valid with MemReq.
- MemAddr  out  MEM_AW  byte address.
- MemWData  out  8  write data.
- MemRData  in  8  read data, valid with MemAck.
- MemAck  in  1  one-cycle completion pulse.
- Busy  out  1  a memory transaction is outstanding.
- Overrun  out  1  one-cycle pulse when an access is dropped.

Behaviour:
Reset values:
- PakDOut=8'hFF, PakAudio=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, Busy=0, Overrun=0.
- RomBank=1, RamBank=0, RamEn=0, FSM=IDLE, pending slot empty.

Bus events:
- Events come from edge detection on registered PakRead/PakWrite.
- Read event: rising edge of PakRead, or PakAddress change while PakRead is high.
- Write event: rising edge of PakWrite.

Decode (address taken from PakAddress at the event):
- Write 0000-1FFF: RamEn = (PakDIn==8'h0A).
- Write 2000-2FFF: RomBank[7:0] = PakDIn.
- Write 3000-3FFF: RomBank[8] = PakDIn[0].
- Write 4000-5FFF: RamBank = PakDIn[3:0].
- Register writes complete in the event cycle, generate no memory traffic, and are accepted even when Busy.
- Read 0000-3FFF: MemAddr = {0, A[13:0]}.
- Read 4000-7FFF: MemAddr = {0, (RomBank & ROM_BANK_MASK), A[13:0]}. Bank 0 is legal here; no 0->1 remap.
- A000-BFFF with PakCS=1 and RamEn=1: MemAddr = {1, 0..., RamBank, A[12:0]}. Reads and writes both go to memory.
- A000-BFFF with RamEn=0 or PakCS=0: read returns 8'hFF without a memory access; write is ignored.
- Writes to 6000-7FFF, 8000-9FFF, C000-FFFF: ignored. Reads of 8000-9FFF, C000-FFFF: PakDOut=8'hFF, no memory access.

FSM:
- IDLE -> REQ on an accepted memory event.
- REQ: assert MemReq with MemWe, MemAddr and MemWData stable. Hold until MemAck.
- On MemAck: if read, PakDOut <= MemRData in the following cycle. Return to IDLE, or to REQ if the pending slot is full.

Latency and handshake:
- Event cycle N -> MemReq=1 in N+1.
- MemAck in cycle M -> PakDOut updated in M+1, and MemReq=0 in M+1 unless a pending access issues back-to-back.
- Busy = (FSM != IDLE).

Boundary conditions:
- Memory event while Busy: stored in the single pending slot.
- Memory event while Busy and the pending slot is full: the event is dropped and Overrun pulses for one cycle.
- Register write coincident with MemAck: both take effect. A pending access decodes with the bank values current at its event cycle; the mapped address is captured at the event.
- PakReset=1: synchronously forces the bank registers to their reset values, clears the pending slot, and lets any in-flight memory request finish without updating PakDOut.
- Reset asserted mid-transaction: MemReq drops immediately (asynchronously); a later MemAck is ignored.

Decomposition:
- gbc_gamepak_pkg holds:
  - the region enum (ROM0, ROMX, VRAM_NONE, XRAM, OTHER);
  - MBC5 register-address constants;
  - the RAM-enable key 8'h0A;
  - the PAK_OPEN_BUS 8'hFF constant.
- Sub-module gbc_mbc5_regs: bank/enable registers plus a combinational mapper (address, region -> MemAddr, hit/open-bus).
- Top level holds the edge detection, pending slot and FSM.

Test Plan:
1. After reset, read 0x4005, MemAck with MemRData=8'h3C -> MemAddr=0x004005, then PakDOut=8'h3C one cycle after the ack.
2. Write 0x2000<=8'h25 and 0x3000<=8'h01, then read 0x4123 -> MemAddr=0x00(0x125<<14 | 0x0123)=0x494123; repeat with ROM_BANK_MASK=9'h0FF -> 0x094123.
3. Read 0xA010 with RamEn=0 -> PakDOut=8'hFF, MemReq never asserted. Then write 0x0000<=8'h0A, 0x4000<=8'h03, and write 0xA010<=8'h77 with PakCS=1 -> MemWe=1, MemAddr=0x806010, MemWData=8'h77.
4. Hold MemAck off and issue three reads -> first in flight, second pending, third dropped with a one-cycle Overrun pulse. Two MemReq/MemAck transactions complete back-to-back.
5. Assert PakReset during an outstanding read -> RomBank=1, RamEn=0, PakDOut unchanged at the ack. Assert Reset during MemReq -> MemReq=0 immediately.
6. Write 0x2000<=8'h07 in the same cycle MemAck returns for a prior read -> PakDOut updated and the next 0x4000 read maps to bank 7.
